// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file and its scoreboard.
// The default typedefs match the default DATA_W/NUM_REGS build.
package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int REG_ZERO     = 0;

  function automatic int calc_addr_w(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  typedef logic [DEF_DATA_W-1:0]                reg_data_t;
  typedef logic [calc_addr_w(DEF_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for outstanding loads: per-register busy bits, an incrementally
// maintained population count, and the combinational decode hazard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NUM_REGS = 8,
  localparam int ADDR_W   = calc_addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                alu_we,
  input  logic [ADDR_W-1:0]   alu_waddr,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_waddr,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_issue_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt,
  output logic                hazard
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [ADDR_W:0]     r_busy_cnt;
  logic                w_inc;
  logic                w_dec;

  // A new issue to the same register as a returning load wins: the bit stays set.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy_bit
    assign w_busy_next[gi] =
      (ld_issue && (ld_issue_addr == ADDR_W'(gi))) ? 1'b1 :
      (ld_we    && (ld_waddr      == ADDR_W'(gi))) ? 1'b0 :
      r_busy[gi];
  end

  assign w_inc = ld_issue && !r_busy[ld_issue_addr];
  assign w_dec = ld_we && r_busy[ld_waddr] &&
                 !(ld_issue && (ld_issue_addr == ld_waddr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      case ({w_inc, w_dec})
        2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
        2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_busy_cnt;
  assign hazard   = (rd_en_a && r_busy[rd_addr_a]) ||
                    (rd_en_b && r_busy[rd_addr_b]) ||
                    (alu_we  && r_busy[alu_waddr]);

endmodule

// File: rtl/regfile_sb.sv
// Register file with two async read ports, ALU/load write ports (ALU wins on collision)
// and a load scoreboard. Optional same-cycle write bypass under `REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  NUM_REGS    = 8,
  parameter int  ZERO_REG_EN = 0,
  localparam int ADDR_W      = calc_addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  input  logic                rd_en_a,
  input  logic                rd_en_b,
  input  logic                alu_we,
  input  logic [ADDR_W-1:0]   alu_waddr,
  input  logic [DATA_W-1:0]   alu_wdata,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_waddr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_issue_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt,
  output logic                hazard
);

  localparam bit ZERO_EN = (ZERO_REG_EN != 0);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_alu_we;
  logic              w_ld_we;
  logic              w_ld_issue;
  logic [ADDR_W-1:0] w_rd_addr [2];

  // With a hardwired r0, every write or issue aimed at it is simply dropped.
  assign w_alu_we   = alu_we   && !(ZERO_EN && (alu_waddr     == ADDR_W'(REG_ZERO)));
  assign w_ld_we    = ld_we    && !(ZERO_EN && (ld_waddr      == ADDR_W'(REG_ZERO)));
  assign w_ld_issue = ld_issue && !(ZERO_EN && (ld_issue_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_ld_we)  r_regs[ld_waddr]  <= ld_wdata;
      if (w_alu_we) r_regs[alu_waddr] <= alu_wdata;
    end
  end

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    logic [DATA_W-1:0] w_data;
    always_comb begin
      w_data = r_regs[w_rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
      if (w_alu_we && (alu_waddr == w_rd_addr[gi])) begin
        w_data = alu_wdata;
      end else if (w_ld_we && (ld_waddr == w_rd_addr[gi])) begin
        w_data = ld_wdata;
      end
`endif
      if (ZERO_EN && (w_rd_addr[gi] == ADDR_W'(REG_ZERO))) begin
        w_data = '0;
      end
    end
  end

  assign rd_data_a = g_rd_port[0].w_data;
  assign rd_data_b = g_rd_port[1].w_data;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en_a       (rd_en_a),
    .rd_addr_a     (rd_addr_a),
    .rd_en_b       (rd_en_b),
    .rd_addr_b     (rd_addr_b),
    .alu_we        (alu_we),
    .alu_waddr     (alu_waddr),
    .ld_we         (w_ld_we),
    .ld_waddr      (ld_waddr),
    .ld_issue      (w_ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .busy          (busy),
    .busy_cnt      (busy_cnt),
    .hazard        (hazard)
  );

endmodule
